// File: rtl/wd279x_id_scanner.sv
// WD279x-style ID address mark scanner.
// Hunts for three A1 sync marks followed by an FE ID mark, collects the six
// ID bytes (track, side, sector, length, CRC hi, CRC lo) and checks the
// CCITT CRC over marks, FE and all six bytes. A good field leaves 0000 in
// the CRC register. A further A1 after the third mark keeps the CRC of
// exactly three marks, so a long run of marks still verifies correctly.
module wd279x_id_scanner (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [7:0]      byte_in,
  input  logic            byte_stb,
  input  logic            mark_in,
  output logic [5:0][7:0] sec_id,
  output logic            data_valid,
  output logic            crc_error,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, SYNC, COLLECT, CHECK} state_t;

  localparam logic [7:0]  SYNC_BYTE = 8'hA1;
  localparam logic [7:0]  ID_MARK   = 8'hFE;
  localparam logic [15:0] CRC_PRESET = 16'hFFFF;

  state_t          state_q, state_d;
  logic [1:0]      mark_cnt_q, mark_cnt_d;
  logic [15:0]     crc_q, crc_d;
  logic [2:0]      idx_q, idx_d;
  logic [5:0][7:0] shadow_q, shadow_d;
  logic [5:0][7:0] sec_id_q, sec_id_d;
  logic            data_valid_q, data_valid_d;
  logic            crc_error_q, crc_error_d;

  logic [15:0]     crc_upd;
  logic [15:0]     crc_fresh;
  logic            a1_mark;

  // CCITT 0x1021 update, one byte shifted in MSB first.
  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  assign crc_upd   = crc_step(crc_q, byte_in);
  assign crc_fresh = crc_step(CRC_PRESET, SYNC_BYTE);
  assign a1_mark   = mark_in && (byte_in == SYNC_BYTE);

  // Next-state, CRC, byte capture and result pulses.
  always_comb begin
    state_d      = state_q;
    mark_cnt_d   = mark_cnt_q;
    crc_d        = crc_q;
    idx_d        = idx_q;
    shadow_d     = shadow_q;
    sec_id_d     = sec_id_q;
    data_valid_d = 1'b0;
    crc_error_d  = 1'b0;

    if (!enable) begin
      state_d    = IDLE;
      mark_cnt_d = 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (byte_stb && a1_mark) begin
            state_d    = SYNC;
            mark_cnt_d = 2'd1;
            crc_d      = crc_fresh;
          end
        end
        SYNC: begin
          if (byte_stb) begin
            if (a1_mark) begin
              if (mark_cnt_q != 2'd3) begin
                mark_cnt_d = mark_cnt_q + 2'd1;
                crc_d      = crc_upd;
              end
            end else if (!mark_in && byte_in == ID_MARK && mark_cnt_q == 2'd3) begin
              state_d    = COLLECT;
              mark_cnt_d = 2'd0;
              idx_d      = 3'd0;
              crc_d      = crc_upd;
            end else begin
              state_d    = IDLE;
              mark_cnt_d = 2'd0;
            end
          end
        end
        COLLECT: begin
          if (byte_stb) begin
            if (a1_mark) begin
              state_d    = SYNC;
              mark_cnt_d = 2'd1;
              crc_d      = crc_fresh;
            end else if (mark_in) begin
              state_d    = IDLE;
              mark_cnt_d = 2'd0;
            end else begin
              shadow_d[idx_q] = byte_in;
              crc_d           = crc_upd;
              if (idx_q == 3'd5) state_d = CHECK;
              else               idx_d   = idx_q + 3'd1;
            end
          end
        end
        CHECK: begin
          sec_id_d = shadow_q;
          if (crc_q == 16'h0000) data_valid_d = 1'b1;
          else                   crc_error_d  = 1'b1;
          state_d    = IDLE;
          mark_cnt_d = 2'd0;
        end
        default: begin
          state_d    = IDLE;
          mark_cnt_d = 2'd0;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      mark_cnt_q   <= 2'd0;
      crc_q        <= CRC_PRESET;
      idx_q        <= 3'd0;
      shadow_q     <= '0;
      sec_id_q     <= '0;
      data_valid_q <= 1'b0;
      crc_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      mark_cnt_q   <= mark_cnt_d;
      crc_q        <= crc_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      sec_id_q     <= sec_id_d;
      data_valid_q <= data_valid_d;
      crc_error_q  <= crc_error_d;
    end
  end

  assign sec_id     = sec_id_q;
  assign data_valid = data_valid_q;
  assign crc_error  = crc_error_q;
  assign busy       = (state_q == COLLECT);

endmodule

// File: tb/tb_wd279x_id_scanner.sv
// Scoreboard bench for wd279x_id_scanner: directed ID-field scenarios then
// randomized byte streams, checked against a byte-level reference model.
module tb_wd279x_id_scanner;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            enable = 1'b0;
  logic [7:0]      byte_in = 8'h00;
  logic            byte_stb = 1'b0;
  logic            mark_in = 1'b0;
  logic [5:0][7:0] sec_id;
  logic            data_valid;
  logic            crc_error;
  logic            busy;

  wd279x_id_scanner dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .byte_in    (byte_in),
    .byte_stb   (byte_stb),
    .mark_in    (mark_in),
    .sec_id     (sec_id),
    .data_valid (data_valid),
    .crc_error  (crc_error),
    .busy       (busy)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  int cyc = 0;

  // Rising-edge counter used to timestamp expected result pulses.
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit              good;
    logic [5:0][7:0] bytes;
    int              due;
  } exp_t;

  exp_t            exp_q[$];
  logic [5:0][7:0] exp_sec = '0;
  bit              mon_on = 1'b0;
  int              n_vec = 0;
  int              n_bad = 0;
  int              n_dv = 0;
  int              n_ce = 0;

  // Reference model: count of consecutive A1 marks, whether an ID field is
  // being gathered, the bytes gathered so far, and a finished field waiting
  // for its one-cycle verdict.
  int         m_marks = 0;
  bit         m_collect = 1'b0;
  logic [7:0] m_got[$];
  bit         m_pending = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // CRC-CCITT computed byte-wise over an arbitrary byte list.
  function automatic logic [15:0] crc16_of(input logic [7:0] bytes[$]);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (bytes[k]) begin
      c = c ^ {bytes[k], 8'h00};
      repeat (8) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  function automatic logic [15:0] id_crc(input logic [7:0] d0, input logic [7:0] d1,
                                         input logic [7:0] d2, input logic [7:0] d3);
    logic [7:0] q[$];
    q = '{8'hA1, 8'hA1, 8'hA1, 8'hFE, d0, d1, d2, d3};
    return crc16_of(q);
  endfunction

  task automatic model_reset();
    m_marks   = 0;
    m_collect = 1'b0;
    m_got.delete();
    m_pending = 1'b0;
  endtask

  task automatic model_step(input bit en, input bit stb, input bit mk, input logic [7:0] b);
    logic [7:0] q[$];
    exp_t       e;
    if (!en) begin
      model_reset();
      return;
    end
    if (m_pending) begin
      q = '{8'hA1, 8'hA1, 8'hA1, 8'hFE};
      foreach (m_got[k]) begin
        q.push_back(m_got[k]);
        e.bytes[k] = m_got[k];
      end
      e.good = (crc16_of(q) == 16'h0000);
      e.due  = cyc + 1;
      exp_q.push_back(e);
      model_reset();
      return;
    end
    if (!stb) return;
    if (m_collect) begin
      if (mk) begin
        model_reset();
        m_marks = (b == 8'hA1) ? 1 : 0;
      end else begin
        m_got.push_back(b);
        if (m_got.size() == 6) begin
          m_collect = 1'b0;
          m_pending = 1'b1;
        end
      end
    end else if (m_marks == 0) begin
      if (mk && b == 8'hA1) m_marks = 1;
    end else if (mk) begin
      m_marks = (b == 8'hA1) ? ((m_marks < 3) ? m_marks + 1 : 3) : 0;
    end else if (b == 8'hFE && m_marks == 3) begin
      m_marks   = 0;
      m_collect = 1'b1;
      m_got.delete();
    end else begin
      m_marks = 0;
    end
  endtask

  // One clock of stimulus; busy from the previous cycle is checked first.
  task automatic apply_stimulus(input bit en, input bit stb, input bit mk, input logic [7:0] b);
    @(negedge clk);
    check("busy", busy, m_collect);
    enable   = en;
    byte_stb = stb;
    mark_in  = mk;
    byte_in  = b;
    model_step(en, stb, mk, b);
  endtask

  task automatic send(input bit mk, input logic [7:0] b, input int gap);
    apply_stimulus(1'b1, 1'b1, mk, b);
    repeat (gap) apply_stimulus(1'b1, 1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic idle(input int n);
    repeat (n) apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_marks(input int n);
    repeat (n) send(1'b1, 8'hA1, 0);
  endtask

  task automatic send_field(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                            input logic [7:0] d3, input logic [7:0] hi, input logic [7:0] lo,
                            input int gap);
    send(1'b0, 8'hFE, gap);
    send(1'b0, d0, gap);
    send(1'b0, d1, gap);
    send(1'b0, d2, gap);
    send(1'b0, d3, gap);
    send(1'b0, hi, gap);
    send(1'b0, lo, gap);
  endtask

  // Monitor: pops the scoreboard whenever a result pulse appears and checks
  // that sec_id only moves when a verdict is delivered.
  initial begin
    exp_t e;
    wait (mon_on);
    forever begin
      @(negedge clk);
      if (reset) continue;
      check("pulse_exclusive", {data_valid, crc_error} == 2'b11, 1'b0);
      if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        e = exp_q.pop_front();
        n_vec++;
        n_bad++;
        $display("[TB] FAIL missing_pulse: got none, required %s at cycle %0d",
                 e.good ? "data_valid" : "crc_error", e.due);
      end
      if (data_valid || crc_error) begin
        if (data_valid) n_dv++;
        if (crc_error)  n_ce++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("[TB] FAIL unexpected_pulse: got dv=%0b ce=%0b, required none (cycle %0d)",
                   data_valid, crc_error, cyc);
        end else begin
          e = exp_q.pop_front();
          check("pulse_kind", {data_valid, crc_error}, e.good ? 2'b10 : 2'b01);
          check("pulse_cycle", cyc, e.due);
          exp_sec = e.bytes;
        end
      end
      check("sec_id", sec_id, exp_sec);
    end
  end

  // Main sequence: reset, directed scenarios, randomized streams, summary.
  initial begin
    int dv0, ce0, kind, gap, extra, nb;
    logic [7:0] d[4];
    logic [15:0] c;

    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_sec_id", sec_id, 48'h0);
    check("reset_dv", data_valid, 1'b0);
    check("reset_ce", crc_error, 1'b0);
    check("reset_busy", busy, 1'b0);
    reset  = 1'b0;
    enable = 1'b1;
    mon_on = 1'b1;

    // Good field straight after reset release.
    dv0 = n_dv; ce0 = n_ce;
    send_marks(3);
    send_field(8'h00, 8'h00, 8'h01, 8'h02, 8'hCA, 8'h6F, 0);
    idle(4);
    check("good_dv_count", n_dv - dv0, 1);
    check("good_ce_count", n_ce - ce0, 0);
    check("good_sec_id", sec_id, 48'h6FCA02010000);

    // Corrupted CRC low byte.
    dv0 = n_dv; ce0 = n_ce;
    send_marks(3);
    send_field(8'h00, 8'h00, 8'h01, 8'h02, 8'hCA, 8'h6E, 1);
    idle(4);
    check("bad_dv_count", n_dv - dv0, 0);
    check("bad_ce_count", n_ce - ce0, 1);
    check("bad_sec5", sec_id[5], 8'h6E);

    // Only two sync marks: field must be ignored.
    dv0 = n_dv; ce0 = n_ce;
    send_marks(2);
    send_field(8'h00, 8'h00, 8'h01, 8'h02, 8'hCA, 8'h6F, 0);
    idle(4);
    check("twomark_pulses", (n_dv - dv0) + (n_ce - ce0), 0);
    check("twomark_sec_id", sec_id, 48'h6FCA02010000 - 48'h010000000000);

    // Data mark instead of ID mark.
    dv0 = n_dv; ce0 = n_ce;
    send_marks(3);
    send(1'b0, 8'hFB, 0);
    for (int i = 0; i < 8; i++) send(1'b0, 8'(i * 37), 0);
    idle(4);
    check("datamark_pulses", (n_dv - dv0) + (n_ce - ce0), 0);

    // Field interrupted by a new A1 mark, then a complete field.
    dv0 = n_dv; ce0 = n_ce;
    c = id_crc(8'h05, 8'h00, 8'h03, 8'h02);
    send_marks(3);
    send(1'b0, 8'hFE, 0);
    send(1'b0, 8'h05, 0);
    send(1'b0, 8'h00, 0);
    send_marks(3);
    send_field(8'h05, 8'h00, 8'h03, 8'h02, c[15:8], c[7:0], 0);
    idle(4);
    check("resync_dv_count", n_dv - dv0, 1);
    check("resync_ce_count", n_ce - ce0, 0);
    check("resync_sec0", sec_id[0], 8'h05);
    check("resync_sec2", sec_id[2], 8'h03);

    // Asynchronous reset after the third ID byte.
    dv0 = n_dv; ce0 = n_ce;
    send_marks(3);
    send(1'b0, 8'hFE, 0);
    send(1'b0, 8'h07, 0);
    send(1'b0, 8'h01, 0);
    send(1'b0, 8'h09, 0);
    #2 reset = 1'b1;
    #1;
    check("async_sec_id", sec_id, 48'h0);
    check("async_busy", busy, 1'b0);
    check("async_dv", data_valid, 1'b0);
    check("async_ce", crc_error, 1'b0);
    model_reset();
    exp_q.delete();
    exp_sec = '0;
    @(negedge clk);
    reset = 1'b0;
    c = id_crc(8'h07, 8'h01, 8'h09, 8'h02);
    send(1'b0, 8'h02, 0);
    send(1'b0, c[15:8], 0);
    send(1'b0, c[7:0], 0);
    idle(4);
    check("async_no_pulse", (n_dv - dv0) + (n_ce - ce0), 0);

    // Enable dropped mid-field, then an A1 strobe coinciding with enable rising.
    dv0 = n_dv;
    send_marks(3);
    send(1'b0, 8'hFE, 0);
    send(1'b0, 8'h11, 0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 8'h22);
    c = id_crc(8'h11, 8'h00, 8'h04, 8'h01);
    apply_stimulus(1'b1, 1'b1, 1'b1, 8'hA1);
    send_marks(2);
    send_field(8'h11, 8'h00, 8'h04, 8'h01, c[15:8], c[7:0], 0);
    idle(4);
    check("enable_rise_dv", n_dv - dv0, 1);

    // Randomized streams of good, bad, partial and noisy fields.
    for (int it = 0; it < 300; it++) begin
      kind = $urandom_range(0, 6);
      gap  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      for (int k = 0; k < 4; k++) d[k] = 8'($urandom);
      c = id_crc(d[0], d[1], d[2], d[3]);
      case (kind)
        0, 1: begin
          extra = $urandom_range(0, 1);
          send_marks(3 + extra);
          if (kind == 1) c[$urandom_range(0, 15)] ^= 1'b1;
          send_field(d[0], d[1], d[2], d[3], c[15:8], c[7:0], gap);
        end
        2: begin
          send_marks($urandom_range(1, 2));
          send_field(d[0], d[1], d[2], d[3], c[15:8], c[7:0], gap);
        end
        3: begin
          send_marks(3);
          send(1'b0, ($urandom_range(0, 1) == 1) ? 8'hFB : 8'hF8, gap);
          for (int k = 0; k < 4; k++) send(1'b0, d[k], gap);
        end
        4: begin
          for (int k = 0; k < 12; k++)
            send($urandom_range(0, 5) == 0,
                 ($urandom_range(0, 2) == 0) ? 8'hA1 : 8'($urandom), gap);
        end
        5: begin
          send_marks(3);
          send(1'b0, 8'hFE, gap);
          nb = $urandom_range(0, 5);
          for (int k = 0; k < nb; k++) send(1'b0, 8'($urandom), gap);
          send(1'b1, ($urandom_range(0, 1) == 1) ? 8'hA1 : 8'hC2, gap);
          send_marks(2);
          send_field(d[0], d[1], d[2], d[3], c[15:8], c[7:0], gap);
        end
        default: begin
          send_marks(3);
          send(1'b0, 8'hFE, 0);
          for (int k = 0; k < 4; k++)
            apply_stimulus($urandom_range(0, 3) != 0, 1'b1, 1'b0, d[k]);
          apply_stimulus($urandom_range(0, 1) == 1, 1'b1, 1'b0, c[15:8]);
          apply_stimulus($urandom_range(0, 1) == 1, 1'b1, 1'b0, c[7:0]);
          apply_stimulus($urandom_range(0, 1) == 1, 1'b0, 1'b0, 8'h00);
        end
      endcase
      idle($urandom_range(0, 2));
    end

    idle(5);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
